tessent_data_mux_ctrl: RTL

- Sequencer that drives the select line of the IJTAG/functional data-path mux and the data the mux outputs in test mode.
- On an IJTAG override request it handshakes with the functional logic: asserts a hold request, waits for the functional side to report idle, waits out a guard interval, then switches the mux.
- Release runs the same steps in reverse.
- Sits between the IJTAG TDR bits (request, shadow data, update strobe) and the mux's `ijtag_select` / `ijtag_data_in` inputs.

---
 rtl/tessent_data_mux_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/tessent_data_mux_ctrl.sv
// rtl/tessent_data_mux_ctrl.sv - IJTAG/functional data-path mux override sequencer
//
// Sequences takeover of a functional data path by IJTAG: raises a hold
// request, waits for the functional side to go idle (bounded by a timeout),
// waits a guard interval, then switches the mux. Release runs in reverse.
//
// Optional feature macro: TESSENT_DATA_MUX_CTRL_SNAPSHOT_EN
//   adds func_data_in / snapshot_data, capturing the functional value on the
//   edge that enters ACTIVE.
//
// Ports:
//   ijtag_tck        clock, rising edge
//   ijtag_reset      asynchronous active-low reset
//   override_req     TDR level request to take over the data path
//   func_idle        functional side quiesced (synchronous to ijtag_tck)
//   data_update      one-cycle strobe, loads shadow_data_in
//   shadow_data_in   TDR shadow value driven in test mode
//   err_clr          clears timeout_err
//   func_hold_req    asks the functional side to quiesce
//   ijtag_select     mux select
//   ijtag_data_out   mux ijtag_data_in
//   override_active  copy of ijtag_select for TDR status
//   timeout_err      sticky hold-handshake timeout flag
//   ctrl_state       IDLE=0 HOLD_REQ=1 SETTLE=2 ACTIVE=3 RELEASE=4
//   func_data_in     (snapshot build) functional data value
//   snapshot_data    (snapshot build) functional value captured at takeover

module tessent_data_mux_ctrl #(
  parameter int WIDTH          = 19,
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             override_req,
  input  logic             func_idle,
  input  logic             data_update,
  input  logic [WIDTH-1:0] shadow_data_in,
  input  logic             err_clr,
`ifdef TESSENT_DATA_MUX_CTRL_SNAPSHOT_EN
  input  logic [WIDTH-1:0] func_data_in,
  output logic [WIDTH-1:0] snapshot_data,
`endif
  output logic             func_hold_req,
  output logic             ijtag_select,
  output logic [WIDTH-1:0] ijtag_data_out,
  output logic             override_active,
  output logic             timeout_err,
  output logic [2:0]       ctrl_state
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HOLD_REQ = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_ACTIVE   = 3'd3,
    ST_RELEASE  = 3'd4
  } state_t;

  // Terminal counts: the counters start at 0 on state entry, so the last
  // cycle of an N-cycle interval is at count N-1.
  localparam logic [3:0]  GUARD_LAST   = 4'(GUARD_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  guard_cnt, guard_cnt_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt;
  logic        rearm, rearm_nxt;
  logic        timeout_fire;

  always_comb begin
    state_nxt     = state;
    guard_cnt_nxt = guard_cnt;
    wait_cnt_nxt  = wait_cnt;
    rearm_nxt     = rearm;
    timeout_fire  = 1'b0;
    case (state)
      ST_IDLE: begin
        // A request only counts once it has been seen low after a timeout,
        // so a stuck-high request cannot keep re-raising the hold.
        if (!override_req) begin
          rearm_nxt = 1'b1;
        end else if (rearm) begin
          state_nxt    = ST_HOLD_REQ;
          wait_cnt_nxt = '0;
        end
      end
      ST_HOLD_REQ: begin
        // func_idle takes priority over both abandonment and timeout.
        if (func_idle) begin
          state_nxt     = ST_SETTLE;
          guard_cnt_nxt = '0;
        end else if (!override_req) begin
          state_nxt = ST_IDLE;
        end else if (wait_cnt == TIMEOUT_LAST) begin
          state_nxt    = ST_IDLE;
          timeout_fire = 1'b1;
          rearm_nxt    = 1'b0;
        end else begin
          wait_cnt_nxt = wait_cnt + 16'd1;
        end
      end
      ST_SETTLE: begin
        if (!override_req) begin
          state_nxt     = ST_RELEASE;
          guard_cnt_nxt = '0;
        end else if (guard_cnt == GUARD_LAST) begin
          state_nxt = ST_ACTIVE;
        end else begin
          guard_cnt_nxt = guard_cnt + 4'd1;
        end
      end
      ST_ACTIVE: begin
        if (!override_req) begin
          state_nxt     = ST_RELEASE;
          guard_cnt_nxt = '0;
        end
      end
      ST_RELEASE: begin
        // Requests are ignored here; the full guard interval always runs.
        if (guard_cnt == GUARD_LAST) begin
          state_nxt = ST_IDLE;
        end else begin
          guard_cnt_nxt = guard_cnt + 4'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register, with no decode glitches at the mux.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state           <= ST_IDLE;
      guard_cnt       <= '0;
      wait_cnt        <= '0;
      rearm           <= 1'b1;
      func_hold_req   <= 1'b0;
      ijtag_select    <= 1'b0;
      override_active <= 1'b0;
      timeout_err     <= 1'b0;
      ijtag_data_out  <= '0;
    end else begin
      state           <= state_nxt;
      guard_cnt       <= guard_cnt_nxt;
      wait_cnt        <= wait_cnt_nxt;
      rearm           <= rearm_nxt;
      func_hold_req   <= (state_nxt != ST_IDLE);
      ijtag_select    <= (state_nxt == ST_ACTIVE);
      override_active <= (state_nxt == ST_ACTIVE);
      if (timeout_fire) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
      if (data_update) begin
        ijtag_data_out <= shadow_data_in;
      end
    end
  end

  assign ctrl_state = state;

`ifdef TESSENT_DATA_MUX_CTRL_SNAPSHOT_EN
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      snapshot_data <= '0;
    end else if (state_nxt == ST_ACTIVE && state != ST_ACTIVE) begin
      snapshot_data <= func_data_in;
    end
  end
`endif

endmodule
